// File: rtl/register_file.sv
// register_file: DEPTH x WIDTH register file with two combinational read
// ports and one synchronous write port. Entry 0 is hardwired to zero and
// addresses at or beyond DEPTH read as zero and ignore writes.
module register_file #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [AW-1:0]    A1,
  input  logic [AW-1:0]    A2,
  input  logic [AW-1:0]    A3,
  input  logic             WE3,
  input  logic [WIDTH-1:0] WD3,
  output logic [WIDTH-1:0] RD1,
  output logic [WIDTH-1:0] RD2
);

  // Entry 0 is never stored; reads of it fall through to the zero default.
  logic [WIDTH-1:0] mem [1:DEPTH-1];

  // One flop row per entry; exact address decode makes A3=0 and A3>=DEPTH
  // match no row, so those writes drop without extra range logic.
  for (genvar g = 1; g < DEPTH; g++) begin : g_entry
    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        mem[g] <= '0;
      end else if (WE3 && (A3 == AW'(g))) begin
        mem[g] <= WD3;
      end
    end
  end

  // Read muxes: zero unless the address decodes to a stored entry.
  always_comb begin
    RD1 = '0;
    RD2 = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (A1 == AW'(i)) RD1 = mem[i];
      if (A2 == AW'(i)) RD2 = mem[i];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed, table-driven bench for register_file at DEPTH=100, WIDTH=32.
`timescale 1ns/1ps
module tb_register_file;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 100;
  localparam int unsigned AW    = 7;

  logic             Clk;
  logic             Rst;
  logic [AW-1:0]    A1;
  logic [AW-1:0]    A2;
  logic [AW-1:0]    A3;
  logic             WE3;
  logic [WIDTH-1:0] WD3;
  logic [WIDTH-1:0] RD1;
  logic [WIDTH-1:0] RD2;

  logic clk_en;
  int   pass_cnt;
  int   total_cnt;

  typedef struct {
    logic [AW-1:0]    a1;
    logic [AW-1:0]    a2;
    logic [WIDTH-1:0] e1;
    logic [WIDTH-1:0] e2;
  } vec_t;

  vec_t vecs [8];

  register_file #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .A1  (A1),
    .A2  (A2),
    .A3  (A3),
    .WE3 (WE3),
    .WD3 (WD3),
    .RD1 (RD1),
    .RD2 (RD2)
  );

  // Gateable clock so the reset-clear test can run with no edges at all.
  always begin
    #5;
    if (clk_en) Clk = ~Clk;
  end

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic probe(input string name, input logic [AW-1:0] a1,
                       input logic [AW-1:0] a2, input logic [WIDTH-1:0] e1,
                       input logic [WIDTH-1:0] e2);
    A1 = a1;
    A2 = a2;
    #1;
    check({name, ".rd1"}, RD1, e1);
    check({name, ".rd2"}, RD2, e2);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    @(negedge Clk);
    A3  = a;
    WD3 = d;
    WE3 = 1'b1;
    @(posedge Clk);
    #1;
    WE3 = 1'b0;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    Clk = 1'b0;
    clk_en = 1'b1;
    Rst = 1'b1;
    A1 = '0; A2 = '0; A3 = '0; WE3 = 1'b0; WD3 = '0;

    vecs[0] = '{a1: 7'd0,   a2: 7'd1,  e1: 32'd0, e2: 32'd1};
    vecs[1] = '{a1: 7'd2,   a2: 7'd3,  e1: 32'd2, e2: 32'd3};
    vecs[2] = '{a1: 7'd4,   a2: 7'd5,  e1: 32'd4, e2: 32'd5};
    vecs[3] = '{a1: 7'd5,   a2: 7'd5,  e1: 32'd5, e2: 32'd5};
    vecs[4] = '{a1: 7'd6,   a2: 7'd0,  e1: 32'd0, e2: 32'd0};
    vecs[5] = '{a1: 7'd120, a2: 7'd99, e1: 32'd0, e2: 32'h0000_0099};
    vecs[6] = '{a1: 7'd127, a2: 7'd1,  e1: 32'd0, e2: 32'd1};
    vecs[7] = '{a1: 7'd98,  a2: 7'd100, e1: 32'd0, e2: 32'd0};

    // Reset state
    #12;
    probe("reset_state", 7'd1, 7'd2, 32'd0, 32'd0);
    @(negedge Clk);
    Rst = 1'b0;

    // Preload 1..5, then clear with the clock stopped
    for (int k = 1; k <= 5; k++) do_write(AW'(k), 32'h100 + WIDTH'(k));
    probe("preload", 7'd3, 7'd5, 32'h103, 32'h105);
    @(negedge Clk);
    clk_en = 1'b0;
    #1;
    Rst = 1'b1;
    #1;
    for (int k = 0; k <= 5; k++) probe($sformatf("async_clear%0d", k), AW'(k), AW'(k + 1), 32'd0, 32'd0);
    Rst = 1'b0;
    #1;
    clk_en = 1'b1;

    // Sequential write k -> k, including the ignored write to 0
    for (int k = 0; k <= 5; k++) do_write(AW'(k), WIDTH'(k));
    do_write(7'd99, 32'h0000_0099);
    for (int i = 0; i < 8; i++)
      probe($sformatf("vec%0d", i), vecs[i].a1, vecs[i].a2, vecs[i].e1, vecs[i].e2);

    // Zero register ignores writes
    do_write(7'd0, 32'hDEAD_BEEF);
    probe("zero_reg", 7'd0, 7'd0, 32'd0, 32'd0);

    // WE3=0 leaves entry 7 untouched
    @(negedge Clk);
    A3 = 7'd7; WD3 = 32'h1234; WE3 = 1'b0;
    @(posedge Clk);
    #1;
    probe("we_low", 7'd7, 7'd7, 32'd0, 32'd0);

    // Same-cycle read/write of entry 9: old value before the edge
    @(negedge Clk);
    A1 = 7'd9; A3 = 7'd9; WD3 = 32'hA5A5_A5A5; WE3 = 1'b1;
    #1;
    check("rw_before", RD1, 32'd0);
    @(posedge Clk);
    #1;
    check("rw_after", RD1, 32'hA5A5_A5A5);
    WE3 = 1'b0;

    // Out-of-range write touches nothing (120 aliases 56 in 6 bits, 20 mod 100)
    do_write(7'd120, 32'hCAFE_F00D);
    probe("oor_read", 7'd120, 7'd56, 32'd0, 32'd0);
    probe("oor_alias", 7'd20, 7'd99, 32'd0, 32'h0000_0099);

    // Reset beats a simultaneous write to entry 10 and clears everything
    @(negedge Clk);
    A1 = 7'd9; A3 = 7'd10; WD3 = 32'h5555_AAAA; WE3 = 1'b1;
    #1;
    Rst = 1'b1;
    #1;
    check("rst_async9", RD1, 32'd0);
    @(posedge Clk);
    #1;
    probe("rst_prio", 7'd10, 7'd99, 32'd0, 32'd0);

    // First edge after release commits a write normally
    @(negedge Clk);
    Rst = 1'b0;
    A3 = 7'd11; WD3 = 32'h0BAD_F00D; WE3 = 1'b1;
    @(posedge Clk);
    #1;
    WE3 = 1'b0;
    probe("post_release", 7'd11, 7'd10, 32'h0BAD_F00D, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
